// File: rtl/wifi_tx_scrambler_if.sv
// Serial bit stream bundle: one data bit plus its qualifier.
// Used between serializer, scrambler and convolutional encoder.
interface wifi_tx_scrambler_if;
  logic valid;
  logic data;

  modport master (
    output valid,
    output data
  );

  modport slave (
    input valid,
    input data
  );
endinterface

// File: rtl/wifi_tx_scrambler.sv
// 802.11 frame-synchronous scrambler (x^7+x^4+1) with tail zeroing.
// Optional WIFI_TX_SCRAMBLER_BYPASS_EN adds i_bypass for unscrambled frames.
module wifi_tx_scrambler #(
  parameter int DATA_WIDTH = 32,
  parameter int TAIL_BITS  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_start,
  input  logic [6:0]            i_seed,
  input  logic [DATA_WIDTH-1:0] i_data_len,
  input  logic [DATA_WIDTH-1:0] i_total_len,
`ifdef WIFI_TX_SCRAMBLER_BYPASS_EN
  input  logic                  i_bypass,
`endif
  wifi_tx_scrambler_if.slave    s_in,
  wifi_tx_scrambler_if.master   m_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [6:0]            o_state_out
);

  localparam int W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t                r_state;
  state_t                w_nstate;
  logic [6:0]            r_lfsr;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic                  r_dout;
  logic                  r_vout;
  logic                  r_done;

  logic [W-1:0] w_k;
  logic [W-1:0] w_k1;
  logic [W-1:0] w_dl;
  logic [W-1:0] w_te;
  logic [W-1:0] w_tl;
  logic         w_fire;
  logic         w_fb;
  logic         w_tail;
  logic         w_bit;
  logic         w_scr;
  logic         w_adv;
  logic [6:0]   w_seed;

`ifdef WIFI_TX_SCRAMBLER_BYPASS_EN
  logic r_byp;
  assign w_adv = ~r_byp;
  assign w_scr = r_byp ? s_in.data : (s_in.data ^ w_fb);
`else
  assign w_adv = 1'b1;
  assign w_scr = s_in.data ^ w_fb;
`endif

  // Widened so data_len + TAIL_BITS never wraps.
  assign w_k    = {1'b0, r_cnt};
  assign w_k1   = w_k + W'(1);
  assign w_dl   = {1'b0, i_data_len};
  assign w_te   = w_dl + W'(TAIL_BITS);
  assign w_tl   = {1'b0, i_total_len};
  assign w_fire = (r_state == S_RUN) & s_in.valid & i_enable;
  assign w_fb   = r_lfsr[6] ^ r_lfsr[3];
  assign w_tail = (w_k >= w_dl) & (w_k < w_te);
  assign w_seed = (i_seed == 7'd0) ? 7'h7F : i_seed;

  always_comb begin
    w_bit = 1'b0;
    unique case (1'b1)
      w_tail:  w_bit = 1'b0;
      !w_tail: w_bit = w_scr;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start)
          w_nstate = (i_total_len == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        if (w_fire && (w_k1 == w_tl))
          w_nstate = S_FIN;
      end
      S_FIN:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= 7'h7F;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_vout  <= 1'b0;
      r_done  <= 1'b0;
`ifdef WIFI_TX_SCRAMBLER_BYPASS_EN
      r_byp   <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_done  <= (r_state == S_FIN);
      r_vout  <= w_fire;
      if ((r_state == S_IDLE) && i_start) begin
        r_lfsr <= w_seed;
        r_cnt  <= '0;
`ifdef WIFI_TX_SCRAMBLER_BYPASS_EN
        r_byp  <= i_bypass;
`endif
      end
      if (w_fire) begin
        if (w_adv)
          r_lfsr <= {r_lfsr[5:0], w_fb};
        r_dout <= w_bit;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign m_out.valid = r_vout;
  assign m_out.data  = r_dout;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = r_done;
  assign o_state_out = r_lfsr;

endmodule

// File: tb/tb_wifi_tx_scrambler.sv
// Randomized bench for wifi_tx_scrambler against a sequence-level model.
// Model: scrambler sequence b[n] = b[n-7] ^ b[n-4] seeded from the 7-bit state.
module tb_wifi_tx_scrambler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, start;
  logic [6:0]  seed;
  logic [31:0] dlen, tlen;
  logic        busy, done;
  logic [6:0]  st;

  wifi_tx_scrambler_if s_if ();
  wifi_tx_scrambler_if m_if ();

  wifi_tx_scrambler #(.DATA_WIDTH(32), .TAIL_BITS(6)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_enable    (en),
    .i_start     (start),
    .i_seed      (seed),
    .i_data_len  (dlen),
    .i_total_len (tlen),
    .s_in        (s_if),
    .m_out       (m_if),
    .o_busy      (busy),
    .o_done      (done),
    .o_state_out (st)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt = 0;
  int dcnt = 0;
  bit exp_q[$];
  bit act_q[$];
  bit pat[0:255];
  bit b[0:400];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic void build_seq(input logic [6:0] sd);
    logic [6:0] s;
    s = (sd == 7'd0) ? 7'h7F : sd;
    for (int i = 0; i < 7; i++) b[i] = s[6-i];
    for (int n = 7; n <= 400; n++) b[n] = b[n-7] ^ b[n-4];
  endfunction

  function automatic logic [6:0] mstate(input int k);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[6-i] = b[k+i];
    return r;
  endfunction

  function automatic logic [63:0] pack_act();
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < act_q.size() && i < 64; i++) p[i] = act_q[i];
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.valid) begin
        vcnt++;
        act_q.push_back(m_if.data);
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("data_out", m_if.data, exp_q.pop_front());
      end
      if (done) dcnt++;
    end
  end

  task automatic run_frame(input logic [6:0] sd, input int dl, input int tl,
                           input bit gap, input bit pause, input int abort_at);
    int  k, cyc, pcnt, d0;
    bit  v;
    build_seq(sd);
    exp_q.delete();
    act_q.delete();
    vcnt = 0;
    d0 = dcnt;
    @(negedge clk);
    seed = sd; dlen = tl == 0 ? 0 : dl; dlen = dl; tlen = tl;
    start = 1; en = 1;
    s_if.valid = 1; s_if.data = 1'($urandom);
    @(negedge clk);
    start = 0; s_if.valid = 0;
    if (tl == 0) begin
      chk("zl_busy", busy, 0);
      chk("zl_done_early", done, 0);
      @(negedge clk);
      chk("zl_done", done, 1);
      chk("zl_busy2", busy, 0);
      chk("zl_vout", m_if.valid, 0);
      @(negedge clk);
      chk("zl_done_off", done, 0);
      chk("zl_vcnt", vcnt, 0);
      return;
    end
    chk("busy_run", busy, 1);
    k = 0; cyc = 0; pcnt = 0;
    while (k < tl && cyc < 4000) begin
      if (k == abort_at) begin
        s_if.valid = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_dout", m_if.data, 0);
        chk("rst_vout", m_if.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", st, 7'h7F);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", dcnt - d0, 0);
        return;
      end
      chk("state_out", st, mstate(k));
      if (pause && k == tl / 2 && pcnt < 5) begin
        en = 0; pcnt++;
      end else en = 1;
      v = gap ? (cyc % 3 == 0) : 1'b1;
      s_if.valid = v;
      s_if.data = pat[k];
      if (v && en) begin
        exp_q.push_back((k >= dl && k < dl + 6) ? 1'b0 : (pat[k] ^ b[k+7]));
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    s_if.valid = 0; en = 1;
    chk("timeout", cyc >= 4000, 0);
    chk("state_end", st, mstate(tl));
    chk("done_early", done, 0);
    @(negedge clk);
    chk("done", done, 1);
    chk("busy_fin", busy, 0);
    chk("vout_fin", m_if.valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("vcount", vcnt, tl);
    chk("exp_left", exp_q.size(), 0);
    chk("done_count", dcnt - d0, 1);
  endtask

  initial begin
    logic [63:0] ref1, ref2;
    logic [7:0]  f8;
    int sd, dl, tl;
    en = 1; start = 0; seed = 0; dlen = 0; tlen = 0;
    s_if.valid = 0; s_if.data = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_vout", m_if.valid, 0);
    chk("reset_dout", m_if.data, 0);
    chk("reset_state", st, 7'h7F);
    rst_n = 1;

    for (int i = 0; i < 256; i++) pat[i] = 0;
    run_frame(7'h7F, 64, 64, 0, 0, -1);
    for (int i = 0; i < 8; i++) f8[7-i] = act_q[i];
    chk("first8_7F", f8, 8'h0E);
    ref1 = pack_act();
    run_frame(7'h00, 64, 64, 0, 0, -1);
    chk("seed0_eq_7F", pack_act(), ref1);

    for (int i = 0; i < 256; i++) pat[i] = 1'($urandom);
    run_frame(7'h5D, 16, 30, 0, 0, -1);
    f8 = '0;
    for (int i = 16; i < 22; i++) f8[i-16] = act_q[i];
    chk("tail_zero", f8, 0);

    run_frame(7'h3A, 20, 40, 0, 0, -1);
    ref2 = pack_act();
    run_frame(7'h3A, 20, 40, 1, 1, -1);
    chk("gap_eq_plain", pack_act(), ref2);

    run_frame(7'h11, 25, 40, 0, 0, 10);
    run_frame(7'h11, 25, 40, 0, 0, -1);
    run_frame(7'h22, 5, 0, 0, 0, -1);
    run_frame(7'h6B, 28, 30, 0, 0, -1);
    run_frame(7'h09, 50, 20, 1, 0, -1);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 256; i++) pat[i] = 1'($urandom);
      sd = $urandom_range(0, 127);
      tl = $urandom_range(1, 60);
      dl = $urandom_range(0, 70);
      run_frame(7'(sd), dl, tl, 1'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
